// File: rtl/fic_sw_port_mux.sv
// -----------------------------------------------------------------------------
// fic_sw_port_mux
//
// Purpose: merges NPORTS switch ingress streams into one local ingress stream
// through a round-robin arbiter and a small FIFO. It also fans one local egress
// stream out to a selected switch port. A three-state run FSM (IDLE/RUN/DRAIN)
// gates ingress arbitration and emits start/stop pulses.
//
// Optional feature: define FIC_PORTMUX_CNT_EN to build the 32-bit saturating
// ingress beat counter. When the macro is not defined, beat_cnt is tied to 0.
//
// Ports:
//   clk, ap_rst               clock, synchronous active-high reset
//   ap_start                  level-sensitive run request
//   port_en[NPORTS]           per-port enable mask (ingress and egress)
//   out_sel[SW]               egress port select
//   swin_valid/ready/data     per-port ingress handshakes, port i at [i*DW +: DW]
//   swout_valid/ready/data    per-port egress handshakes, same packing
//   loc_in_valid/ready/data   local ingress stream (FIFO head)
//   loc_in_port               source port of the FIFO head
//   loc_out_valid/ready/data  local egress stream
//   startt_valid/stopt_valid  one-cycle run start / run end pulses
//   beat_cnt[32]              ingress grant counter
// -----------------------------------------------------------------------------
module fic_sw_port_mux #(
  parameter int NPORTS     = 4,
  parameter int DW         = 169,
  parameter int FIFO_DEPTH = 4,
  localparam int SW        = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                 clk,
  input  logic                 ap_rst,
  input  logic                 ap_start,
  input  logic [NPORTS-1:0]    port_en,
  input  logic [SW-1:0]        out_sel,
  input  logic [NPORTS-1:0]    swin_valid,
  output logic [NPORTS-1:0]    swin_ready,
  input  logic [NPORTS*DW-1:0] swin_data,
  output logic [NPORTS-1:0]    swout_valid,
  input  logic [NPORTS-1:0]    swout_ready,
  output logic [NPORTS*DW-1:0] swout_data,
  output logic                 loc_in_valid,
  input  logic                 loc_in_ready,
  output logic [DW-1:0]        loc_in_data,
  output logic [SW-1:0]        loc_in_port,
  input  logic                 loc_out_valid,
  output logic                 loc_out_ready,
  input  logic [DW-1:0]        loc_out_data,
  output logic                 startt_valid,
  output logic                 stopt_valid,
  output logic [31:0]          beat_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic            startt_q, startt_d;
  logic            stopt_q, stopt_d;
  logic            run_arb;

  logic [SW-1:0]   rr_ptr_q;
  logic            grant_vld;
  logic [SW-1:0]   grant_idx;

  logic [DW-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [SW-1:0]   fifo_port_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = grant_vld;
  assign pop        = !fifo_empty && loc_in_ready;

  // ---- run FSM: state register ----
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      state_q  <= S_IDLE;
      startt_q <= 1'b0;
      stopt_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      startt_q <= startt_d;
      stopt_q  <= stopt_d;
    end
  end

  // ---- run FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ap_start) state_d = S_RUN;
      S_RUN:   if (!ap_start) state_d = S_DRAIN;
      // An empty FIFO ends the run even if ap_start has come back.
      S_DRAIN: if (fifo_empty) state_d = S_IDLE;
               else if (ap_start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- run FSM: outputs ----
  always_comb begin
    // Reset also blocks grants in its own cycle so no handshake completes
    // into a FIFO that is about to be cleared.
    run_arb  = (state_q == S_RUN) && !ap_rst;
    startt_d = (state_q == S_IDLE)  && (state_d == S_RUN);
    stopt_d  = (state_q == S_DRAIN) && (state_d == S_IDLE);
  end

  assign startt_valid = startt_q;
  assign stopt_valid  = stopt_q;

  // ---- round-robin arbiter: rr_ptr_q is where the next search starts ----
  always_comb begin
    int            idx;
    logic [SW-1:0] idx_s;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_s     = '0;
    if (run_arb && !fifo_full) begin
      for (int k = 0; k < NPORTS; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NPORTS) idx = idx - NPORTS;
        idx_s = SW'(idx);
        if (!grant_vld && port_en[idx_s] && swin_valid[idx_s]) begin
          grant_vld = 1'b1;
          grant_idx = idx_s;
        end
      end
    end
  end

  assign swin_ready = grant_vld ? (NPORTS'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (ap_rst) begin
      rr_ptr_q <= '0;
    end else if (grant_vld) begin
      rr_ptr_q <= (grant_idx == SW'(NPORTS - 1)) ? '0 : grant_idx + SW'(1);
    end
  end

  // ---- ingress FIFO: control ----
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---- ingress FIFO: storage (no reset, guarded by cnt_q) ----
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= swin_data[grant_idx*DW +: DW];
      fifo_port_q[wr_ptr_q] <= grant_idx;
    end
  end

  assign loc_in_valid = !fifo_empty;
  assign loc_in_data  = fifo_data_q[rd_ptr_q];
  assign loc_in_port  = fifo_port_q[rd_ptr_q];

  // ---- egress fan-out: an out-of-range out_sel matches no port ----
  always_comb begin
    swout_valid   = '0;
    swout_data    = '0;
    loc_out_ready = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if ((out_sel == SW'(i)) && port_en[i]) begin
        swout_valid[i]         = loc_out_valid;
        swout_data[i*DW +: DW] = loc_out_data;
        loc_out_ready          = swout_ready[i];
      end
    end
  end

  // ---- beat counter ----
`ifdef FIC_PORTMUX_CNT_EN
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (ap_rst) begin
      beat_cnt_q <= '0;
    end else if (startt_d) begin
      beat_cnt_q <= '0;
    end else if (grant_vld && (beat_cnt_q != 32'hFFFF_FFFF)) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_fic_sw_port_mux.sv
// Self-checking bench for fic_sw_port_mux with a queue-based reference model.
module tb_fic_sw_port_mux;
  localparam int NPORTS     = 4;
  localparam int DW         = 169;
  localparam int FIFO_DEPTH = 4;
  localparam int SW         = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int RW         = ((DW + 31) / 32) * 32;

  logic                 clk = 1'b0;
  logic                 ap_rst, ap_start;
  logic [NPORTS-1:0]    port_en;
  logic [SW-1:0]        out_sel;
  logic [NPORTS-1:0]    swin_valid, swin_ready;
  logic [NPORTS*DW-1:0] swin_data;
  logic [NPORTS-1:0]    swout_valid, swout_ready;
  logic [NPORTS*DW-1:0] swout_data;
  logic                 loc_in_valid, loc_in_ready;
  logic [DW-1:0]        loc_in_data;
  logic [SW-1:0]        loc_in_port;
  logic                 loc_out_valid, loc_out_ready;
  logic [DW-1:0]        loc_out_data;
  logic                 startt_valid, stopt_valid;
  logic [31:0]          beat_cnt;

  always #5 clk = ~clk;

  fic_sw_port_mux #(.NPORTS(NPORTS), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .ap_rst(ap_rst), .ap_start(ap_start), .port_en(port_en),
    .out_sel(out_sel), .swin_valid(swin_valid), .swin_ready(swin_ready),
    .swin_data(swin_data), .swout_valid(swout_valid), .swout_ready(swout_ready),
    .swout_data(swout_data), .loc_in_valid(loc_in_valid), .loc_in_ready(loc_in_ready),
    .loc_in_data(loc_in_data), .loc_in_port(loc_in_port), .loc_out_valid(loc_out_valid),
    .loc_out_ready(loc_out_ready), .loc_out_data(loc_out_data),
    .startt_valid(startt_valid), .stopt_valid(stopt_valid), .beat_cnt(beat_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: 0=idle, 1=run, 2=drain
  int            m_state;
  logic [DW-1:0] mq_data[$];
  int            mq_port[$];
  int            m_ptr;
  logic          m_start, m_stop;
  logic [31:0]   m_cnt;

  // Model expectations for the current cycle
  int                   e_grant;
  logic [NPORTS-1:0]    e_ready;
  logic                 e_liv;
  logic [DW-1:0]        e_lid;
  logic [SW-1:0]        e_lip;
  logic [NPORTS-1:0]    e_sov;
  logic [NPORTS*DW-1:0] e_sod;
  logic                 e_lor;
  logic                 e_start, e_stop;
  logic [31:0]          e_cnt;

  function automatic logic [DW-1:0] rand_flit();
    logic [RW-1:0] t;
    for (int w = 0; w < RW / 32; w++) t[w*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  function automatic int onehot_idx(input logic [NPORTS-1:0] v);
    int r = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < NPORTS; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic rand_swin_data();
    for (int i = 0; i < NPORTS; i++) swin_data[i*DW +: DW] = rand_flit();
  endtask

  task automatic mdl_eval();
    e_grant = -1;
    if (!ap_rst && m_state == 1 && mq_data.size() < FIFO_DEPTH)
      for (int k = 0; k < NPORTS; k++) begin
        int p;
        p = (m_ptr + k) % NPORTS;
        if (e_grant < 0 && port_en[p] && swin_valid[p]) e_grant = p;
      end
    e_ready = '0;
    if (e_grant >= 0) e_ready[e_grant] = 1'b1;
    e_liv = (mq_data.size() > 0);
    e_lid = e_liv ? mq_data[0] : '0;
    e_lip = e_liv ? SW'(mq_port[0]) : '0;
    e_sov = '0;
    e_sod = '0;
    e_lor = 1'b0;
    if (int'(out_sel) < NPORTS && port_en[out_sel]) begin
      e_sov[out_sel]           = loc_out_valid;
      e_sod[out_sel*DW +: DW]  = loc_out_data;
      e_lor                    = swout_ready[out_sel];
    end
    e_start = m_start;
    e_stop  = m_stop;
`ifdef FIC_PORTMUX_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 32'd0;
`endif
  endtask

  task automatic mdl_commit();
    bit was_empty;
    if (ap_rst) begin
      m_state = 0; mq_data.delete(); mq_port.delete();
      m_ptr = 0; m_start = 1'b0; m_stop = 1'b0; m_cnt = 32'd0;
    end else begin
      was_empty = (mq_data.size() == 0);
      if (!was_empty && loc_in_ready) begin
        void'(mq_data.pop_front());
        void'(mq_port.pop_front());
      end
      if (e_grant >= 0) begin
        mq_data.push_back(swin_data[e_grant*DW +: DW]);
        mq_port.push_back(e_grant);
        m_ptr = (e_grant + 1) % NPORTS;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
      m_start = (m_state == 0) && ap_start;
      m_stop  = (m_state == 2) && was_empty;
      if (m_state == 0) begin
        if (ap_start) begin m_state = 1; m_cnt = 32'd0; end
      end else if (m_state == 1) begin
        if (!ap_start) m_state = 2;
      end else begin
        if (was_empty) m_state = 0;
        else if (ap_start) m_state = 1;
      end
    end
  endtask

  task automatic settle();
    #1;
    mdl_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_commit();
    @(negedge clk);
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ap_start = 1'b1; port_en = '1; swin_valid = '1;
    loc_in_ready = 1'b1; rand_swin_data();
    for (int c = 0; c < 3; c++) begin
      settle();
      if (c > 0) begin
        n_checks++;
        if (swin_ready !== '0) begin n_errors++; $display("FAIL rst_swin_ready got=%b exp=0", swin_ready); end
      end
      tick();
    end
    settle();
    n_checks++;
    if (loc_in_valid !== 1'b0) begin n_errors++; $display("FAIL rst_loc_in_valid got=%b exp=0", loc_in_valid); end
    n_checks++;
    if (startt_valid !== 1'b0 || stopt_valid !== 1'b0) begin
      n_errors++; $display("FAIL rst_pulses got=%b%b exp=00", startt_valid, stopt_valid);
    end
    n_checks++;
    if (beat_cnt !== 32'd0) begin n_errors++; $display("FAIL rst_beat_cnt got=%0d exp=0", beat_cnt); end
    ap_rst = 1'b0;
    ap_start = 1'b0;
  endtask

  task automatic test_rr_all();
    int grants[$];
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    int n_start = 0;
    ap_start = 1'b1; port_en = '1; swin_valid = '1; loc_in_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      rand_swin_data();
      settle();
      n_checks++;
      if (swin_ready !== e_ready) begin n_errors++; $display("FAIL rr_swin_ready cyc=%0d got=%b exp=%b", c, swin_ready, e_ready); end
      n_checks++;
      if (loc_in_valid !== e_liv) begin n_errors++; $display("FAIL rr_loc_in_valid cyc=%0d got=%b exp=%b", c, loc_in_valid, e_liv); end
      if (e_liv) begin
        n_checks++;
        if (loc_in_port !== e_lip || loc_in_data !== e_lid) begin
          n_errors++; $display("FAIL rr_loc_in cyc=%0d got port=%0d data=%h exp port=%0d data=%h", c, loc_in_port, loc_in_data, e_lip, e_lid);
        end
      end
      n_checks++;
      if (startt_valid !== e_start) begin n_errors++; $display("FAIL rr_startt cyc=%0d got=%b exp=%b", c, startt_valid, e_start); end
      n_checks++;
      if (beat_cnt !== e_cnt) begin n_errors++; $display("FAIL rr_beat_cnt cyc=%0d got=%0d exp=%0d", c, beat_cnt, e_cnt); end
      if (startt_valid === 1'b1) n_start++;
      if (onehot_idx(swin_ready) >= 0) grants.push_back(onehot_idx(swin_ready));
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= grants.size()) begin
        n_errors++; $display("FAIL rr_order idx=%0d got=none exp=%0d", i, exp_seq[i]);
      end else if (grants[i] != exp_seq[i]) begin
        n_errors++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, grants[i], exp_seq[i]);
      end
    end
    n_checks++;
    if (n_start != 1) begin n_errors++; $display("FAIL rr_startt_count got=%0d exp=1", n_start); end
  endtask

  task automatic test_en_mask();
    int prev = -1;
    int g;
    port_en = 4'b0101; swin_valid = '1; loc_in_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      rand_swin_data();
      settle();
      g = onehot_idx(swin_ready);
      n_checks++;
      if (swin_ready !== e_ready) begin n_errors++; $display("FAIL mask_swin_ready cyc=%0d got=%b exp=%b", c, swin_ready, e_ready); end
      n_checks++;
      if ((g != 0 && g != 2) || g == prev) begin
        n_errors++; $display("FAIL mask_alternate cyc=%0d got=%0d prev=%0d exp=other of 0/2", c, g, prev);
      end
      n_checks++;
      if (swin_ready[1] !== 1'b0 || swin_ready[3] !== 1'b0) begin
        n_errors++; $display("FAIL mask_disabled_ready cyc=%0d got=%b exp=x0x0", c, swin_ready);
      end
      if (e_liv) begin
        n_checks++;
        if (loc_in_port !== e_lip) begin n_errors++; $display("FAIL mask_loc_in_port cyc=%0d got=%0d exp=%0d", c, loc_in_port, e_lip); end
      end
      prev = g;
      tick();
    end
  endtask

  task automatic test_full();
    int n_grant = 0;
    port_en = '1; swin_valid = '0; loc_in_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin settle(); tick(); end
    loc_in_ready = 1'b0; swin_valid = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      rand_swin_data();
      settle();
      n_checks++;
      if (swin_ready !== e_ready) begin n_errors++; $display("FAIL full_swin_ready cyc=%0d got=%b exp=%b", c, swin_ready, e_ready); end
      if (swin_ready[1] === 1'b1) n_grant++;
      tick();
    end
    n_checks++;
    if (n_grant != FIFO_DEPTH) begin n_errors++; $display("FAIL full_grant_count got=%0d exp=%0d", n_grant, FIFO_DEPTH); end
    loc_in_ready = 1'b1;
    settle();
    n_checks++;
    if (swin_ready !== '0) begin n_errors++; $display("FAIL full_pop_no_push got=%b exp=0", swin_ready); end
    n_checks++;
    if (loc_in_valid !== 1'b1 || loc_in_port !== SW'(1) || loc_in_data !== e_lid) begin
      n_errors++; $display("FAIL full_head got v=%b port=%0d data=%h exp v=1 port=1 data=%h", loc_in_valid, loc_in_port, loc_in_data, e_lid);
    end
    tick();
    loc_in_ready = 1'b0;
    settle();
    n_checks++;
    if (swin_ready !== 4'b0010) begin n_errors++; $display("FAIL full_one_pop got=%b exp=0010", swin_ready); end
    tick();
  endtask

  task automatic test_drain();
    int n_pop = 0, n_stop = 0, empty_cyc = -1, stop_cyc = -1;
    swin_valid = '0; loc_in_ready = 1'b1;
    settle(); tick();
    ap_start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      settle();
      n_checks++;
      if (loc_in_valid !== e_liv || stopt_valid !== e_stop) begin
        n_errors++; $display("FAIL drain_state cyc=%0d got liv=%b stop=%b exp liv=%b stop=%b", c, loc_in_valid, stopt_valid, e_liv, e_stop);
      end
      if (e_liv) begin
        n_checks++;
        if (loc_in_data !== e_lid) begin n_errors++; $display("FAIL drain_data cyc=%0d got=%h exp=%h", c, loc_in_data, e_lid); end
      end
      if (loc_in_valid === 1'b1) n_pop++;
      if (loc_in_valid === 1'b0 && empty_cyc < 0) empty_cyc = c;
      if (stopt_valid === 1'b1) begin n_stop++; if (stop_cyc < 0) stop_cyc = c; end
      tick();
    end
    n_checks++;
    if (n_pop != 3) begin n_errors++; $display("FAIL drain_pops got=%0d exp=3", n_pop); end
    n_checks++;
    if (n_stop != 1) begin n_errors++; $display("FAIL drain_stop_count got=%0d exp=1", n_stop); end
    n_checks++;
    if (empty_cyc < 0 || stop_cyc != empty_cyc + 1) begin
      n_errors++; $display("FAIL drain_stop_timing got=%0d exp=%0d", stop_cyc, empty_cyc + 1);
    end
  endtask

  task automatic test_reset_mid();
    ap_start = 1'b1; swin_valid = '0; loc_in_ready = 1'b0; port_en = '1;
    settle(); tick();
    swin_valid = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      rand_swin_data();
      settle();
      n_checks++;
      if (swin_ready !== e_ready) begin n_errors++; $display("FAIL rmid_swin_ready cyc=%0d got=%b exp=%b", c, swin_ready, e_ready); end
      tick();
    end
    swin_valid = '0;
    settle();
    n_checks++;
    if (loc_in_valid !== 1'b1 || beat_cnt !== e_cnt) begin
      n_errors++; $display("FAIL rmid_queued got liv=%b cnt=%0d exp liv=1 cnt=%0d", loc_in_valid, beat_cnt, e_cnt);
    end
    tick();
    ap_rst = 1'b1; ap_start = 1'b0;
    settle(); tick();
    ap_rst = 1'b0;
    settle();
    n_checks++;
    if (loc_in_valid !== 1'b0) begin n_errors++; $display("FAIL rmid_loc_in_valid got=%b exp=0", loc_in_valid); end
    n_checks++;
    if (beat_cnt !== 32'd0) begin n_errors++; $display("FAIL rmid_beat_cnt got=%0d exp=0", beat_cnt); end
    for (int c = 0; c < 4; c++) begin
      settle();
      n_checks++;
      if (stopt_valid !== 1'b0 || startt_valid !== 1'b0) begin
        n_errors++; $display("FAIL rmid_no_pulse cyc=%0d got stop=%b start=%b exp=0", c, stopt_valid, startt_valid);
      end
      tick();
    end
  endtask

  task automatic test_egress();
    out_sel = SW'(2); port_en = 4'b1011; loc_out_valid = 1'b1; swout_ready = '1;
    loc_out_data = rand_flit();
    settle();
    n_checks++;
    if (loc_out_ready !== 1'b0 || swout_valid !== '0) begin
      n_errors++; $display("FAIL egr_disabled got rdy=%b sov=%b exp rdy=0 sov=0", loc_out_ready, swout_valid);
    end
    n_checks++;
    if (swout_data !== '0) begin n_errors++; $display("FAIL egr_disabled_data got=%h exp=0", swout_data); end
    tick();
    port_en = '1;
    settle();
    n_checks++;
    if (swout_valid !== 4'b0100 || loc_out_ready !== 1'b1) begin
      n_errors++; $display("FAIL egr_enabled got sov=%b rdy=%b exp sov=0100 rdy=1", swout_valid, loc_out_ready);
    end
    n_checks++;
    if (swout_data[2*DW +: DW] !== loc_out_data) begin
      n_errors++; $display("FAIL egr_data got=%h exp=%h", swout_data[2*DW +: DW], loc_out_data);
    end
    tick();
    for (int c = 0; c < 24; c++) begin
      out_sel = SW'($urandom_range(0, (1 << SW) - 1));
      port_en = NPORTS'($urandom); loc_out_valid = 1'($urandom);
      swout_ready = NPORTS'($urandom); loc_out_data = rand_flit();
      settle();
      n_checks++;
      if (swout_valid !== e_sov || loc_out_ready !== e_lor || swout_data !== e_sod) begin
        n_errors++; $display("FAIL egr_rand cyc=%0d sel=%0d en=%b got sov=%b rdy=%b exp sov=%b rdy=%b", c, out_sel, port_en, swout_valid, loc_out_ready, e_sov, e_lor);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      ap_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 15) == 0) ap_start = ~ap_start;
      if ($urandom_range(0, 7) == 0) port_en = NPORTS'($urandom);
      swin_valid = NPORTS'($urandom); rand_swin_data();
      loc_in_ready = ($urandom_range(0, 2) != 0);
      out_sel = SW'($urandom); loc_out_valid = 1'($urandom);
      swout_ready = NPORTS'($urandom); loc_out_data = rand_flit();
      settle();
      n_checks++;
      if (swin_ready !== e_ready) begin n_errors++; $display("FAIL rnd_swin_ready cyc=%0d got=%b exp=%b", c, swin_ready, e_ready); end
      n_checks++;
      if (loc_in_valid !== e_liv) begin n_errors++; $display("FAIL rnd_loc_in_valid cyc=%0d got=%b exp=%b", c, loc_in_valid, e_liv); end
      if (e_liv) begin
        n_checks++;
        if (loc_in_port !== e_lip || loc_in_data !== e_lid) begin
          n_errors++; $display("FAIL rnd_loc_in cyc=%0d got port=%0d data=%h exp port=%0d data=%h", c, loc_in_port, loc_in_data, e_lip, e_lid);
        end
      end
      n_checks++;
      if (startt_valid !== e_start || stopt_valid !== e_stop) begin
        n_errors++; $display("FAIL rnd_pulses cyc=%0d got start=%b stop=%b exp start=%b stop=%b", c, startt_valid, stopt_valid, e_start, e_stop);
      end
      n_checks++;
      if (beat_cnt !== e_cnt) begin n_errors++; $display("FAIL rnd_beat_cnt cyc=%0d got=%0d exp=%0d", c, beat_cnt, e_cnt); end
      n_checks++;
      if (swout_valid !== e_sov || loc_out_ready !== e_lor || swout_data !== e_sod) begin
        n_errors++; $display("FAIL rnd_egress cyc=%0d got sov=%b rdy=%b exp sov=%b rdy=%b", c, swout_valid, loc_out_ready, e_sov, e_lor);
      end
      tick();
    end
  endtask

  initial begin
    ap_rst = 1'b1; ap_start = 1'b0; port_en = '0; out_sel = '0;
    swin_valid = '0; swin_data = '0; swout_ready = '0; loc_in_ready = 1'b0;
    loc_out_valid = 1'b0; loc_out_data = '0;
    m_state = 0; m_ptr = 0; m_start = 1'b0; m_stop = 1'b0; m_cnt = 32'd0;
    @(negedge clk);
    test_reset();
    test_rr_all();
    test_en_mask();
    test_full();
    test_drain();
    test_reset_mid();
    test_egress();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
